// File: rtl/mem_responder.sv
// mem_responder: small word-addressed memory with a read/write strobe handshake.
//
// Ports:
//   clk        in   1  single clock, all state on rising edge
//   rst        in   1  asynchronous active-high reset (clears state, outputs, memory)
//   addr       in   5  word address
//   data_in    in   8  write data
//   rd         in   1  read strobe
//   wr         in   1  write strobe
//   data_out   out  8  registered read data
//   data_valid out  1  data_out holds the word for the current read
//   wr_ack     out  1  one-cycle pulse when a write is accepted
//   err        out  1  sticky error flag, cleared only by rst
//
// Parameter:
//   DEPTH  number of 8-bit words (address width fixed at 5, DEPTH <= 32)
//
// Configuration macro:
//   MEM_WRITE_PROTECT_EN  when defined, addresses 0-7 are read-only
module mem_responder #(
    parameter int unsigned DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] addr,
    input  logic [7:0] data_in,
    input  logic       rd,
    input  logic       wr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       wr_ack,
    output logic       err
);

    localparam int unsigned DW         = 8;
    localparam int unsigned PROT_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DW-1:0]     r_mem [DEPTH];

    logic [DW-1:0]     r_data_out;
    logic              r_data_valid;
    logic              r_wr_ack;
    logic              r_err;

    logic [DW-1:0]     w_data_out_d;
    logic              w_data_valid_d;
    logic              w_wr_ack_d;
    logic              w_err_d;
    logic              w_mem_we;

    logic              w_in_range;
    logic              w_writable;
    logic [DW-1:0]     w_rdata;

    // Address decode: out-of-range reads return zero, out-of-range writes are dropped
    assign w_in_range = (32'(addr) < DEPTH);
    assign w_rdata    = w_in_range ? r_mem[addr] : DW'(0);

`ifdef MEM_WRITE_PROTECT_EN
    // Program region at the bottom of memory is read-only
    assign w_writable = w_in_range && (32'(addr) >= PROT_WORDS);
`else
    assign w_writable = w_in_range;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_data_out   <= w_data_out_d;
            r_data_valid <= w_data_valid_d;
            r_wr_ack     <= w_wr_ack_d;
            r_err        <= w_err_d;
        end
    end

    // Memory array; reset clears every word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[addr] <= data_in;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_next_state   = r_state;
        w_data_out_d   = r_data_out;
        w_data_valid_d = 1'b0;
        w_wr_ack_d     = 1'b0;
        w_err_d        = r_err;
        w_mem_we       = 1'b0;

        if (rd && wr) begin
            // Conflicting strobes: treat as a read, never write
            w_next_state   = READ;
            w_data_out_d   = w_rdata;
            w_data_valid_d = 1'b1;
            w_err_d        = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd) begin
                        w_next_state   = READ;
                        w_data_out_d   = w_rdata;
                        w_data_valid_d = 1'b1;
                        if (!w_in_range) w_err_d = 1'b1;
                    end else if (wr) begin
                        // Single commit on entry; ack pulses even if the write is dropped
                        w_next_state = WRITE;
                        w_wr_ack_d   = 1'b1;
                        if (w_writable) w_mem_we = 1'b1;
                        else            w_err_d  = 1'b1;
                    end
                end
                READ: begin
                    // A write strobe here is ignored until IDLE is reached
                    if (wr) w_err_d = 1'b1;
                    if (rd) begin
                        w_data_out_d   = w_rdata;
                        w_data_valid_d = 1'b1;
                        if (!w_in_range) w_err_d = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                WRITE: begin
                    // A read strobe here is ignored until IDLE is reached
                    if (rd) w_err_d = 1'b1;
                    if (!wr) w_next_state = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign wr_ack     = r_wr_ack;
    assign err        = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// strobes/addresses against a transaction-level reference model.
module tb_mem_responder;

    localparam int unsigned TB_DEPTH = 24;

    logic       clk;
    logic       rst;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       rd;
    logic       wr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       wr_ack;
    logic       err;

    int n_checks;
    int n_fail;

    // Reference model: memory image, which access is in progress, expected outputs
    logic [7:0] m_mem [32];
    bit         m_reading;
    bit         m_writing;
    logic [7:0] e_dout;
    bit         e_valid;
    bit         e_ack;
    bit         e_err;

    mem_responder #(.DEPTH(TB_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data_in   (data_in),
        .rd        (rd),
        .wr        (wr),
        .data_out  (data_out),
        .data_valid(data_valid),
        .wr_ack    (wr_ack),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_protected(input int a);
`ifdef MEM_WRITE_PROTECT_EN
        return a < 8;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_reading = 0;
        m_writing = 0;
        e_dout    = 8'h00;
        e_valid   = 0;
        e_ack     = 0;
        e_err     = 0;
    endtask

    // One clock edge of the specified behaviour, seen as a sequence of access rules
    task automatic model_edge(input bit r, input bit w, input int a, input logic [7:0] d);
        bit         ok_addr;
        logic [7:0] word;
        ok_addr = (a < TB_DEPTH);
        word    = ok_addr ? m_mem[a] : 8'h00;
        e_ack   = 0;
        if (r && w) begin
            e_err     = 1;
            m_reading = 1;
            m_writing = 0;
            e_dout    = word;
            e_valid   = 1;
        end else if (m_reading) begin
            if (w) e_err = 1;
            if (r) begin
                e_dout = word;
                if (!ok_addr) e_err = 1;
            end else begin
                m_reading = 0;
                e_valid   = 0;
            end
        end else if (m_writing) begin
            if (r) e_err = 1;
            if (!w) m_writing = 0;
        end else if (r) begin
            m_reading = 1;
            e_dout    = word;
            e_valid   = 1;
            if (!ok_addr) e_err = 1;
        end else if (w) begin
            m_writing = 1;
            e_ack     = 1;
            if (ok_addr && !is_protected(a)) m_mem[a] = d;
            else                             e_err = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"},   32'(data_out),   32'(e_dout));
        check({tag, ".data_valid"}, 32'(data_valid), 32'(e_valid));
        check({tag, ".wr_ack"},     32'(wr_ack),     32'(e_ack));
        check({tag, ".err"},        32'(err),        32'(e_err));
    endtask

    // Apply inputs, take one edge, compare just after it
    task automatic cyc(input string tag, input bit r, input bit w, input int a, input logic [7:0] d);
        rd      = r;
        wr      = w;
        addr    = 5'(a);
        data_in = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(r, w, a, d);
        #1;
        check_outputs(tag);
    endtask

    // Assert reset mid-cycle, verify asynchronous effect, release after one edge
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        data_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset_state");

        // Read of a freshly reset location
        cyc("rd3", 1, 0, 3, 8'h00);
        check("rd3.literal", 32'(data_out), 32'h00);
        cyc("rd_end", 0, 0, 3, 8'h00);

        // Write held for three cycles commits once and acks once
        cyc("wr20_a", 0, 1, 20, 8'hA5);
        check("wr20.ack_first", 32'(wr_ack), 32'h1);
        cyc("wr20_b", 0, 1, 20, 8'h11);
        check("wr20.ack_second", 32'(wr_ack), 32'h0);
        cyc("wr20_c", 0, 1, 20, 8'h22);
        cyc("wr_end", 0, 0, 20, 8'h00);
        cyc("wr21", 0, 1, 21, 8'h3C);
        cyc("wr_end2", 0, 0, 21, 8'h00);

        // Held read with an address step
        cyc("rd20", 1, 0, 20, 8'h00);
        check("rd20.literal", 32'(data_out), 32'hA5);
        cyc("rd21", 1, 0, 21, 8'h00);
        check("rd21.literal", 32'(data_out), 32'h3C);
        check("rd21.valid", 32'(data_valid), 32'h1);
        cyc("rd_drop", 0, 0, 21, 8'h00);
        check("rd_drop.hold", 32'(data_out), 32'h3C);

        // Protected-region write
        cyc("wr2", 0, 1, 2, 8'h77);
        check("wr2.ack", 32'(wr_ack), 32'h1);
        cyc("wr2_end", 0, 0, 2, 8'h00);
        cyc("rd2", 1, 0, 2, 8'h00);
`ifdef MEM_WRITE_PROTECT_EN
        check("rd2.literal", 32'(data_out), 32'h00);
        check("wr2.err", 32'(err), 32'h1);
`else
        check("rd2.literal", 32'(data_out), 32'h77);
        check("wr2.err", 32'(err), 32'h0);
`endif
        cyc("rd2_end", 0, 0, 2, 8'h00);

        // Out-of-range write still acks, then read returns zero
        cyc("wr_oor", 0, 1, 30, 8'h5A);
        cyc("wr_oor_end", 0, 0, 30, 8'h00);
        cyc("rd_oor", 1, 0, 30, 8'h00);
        cyc("rd_oor_end", 0, 0, 30, 8'h00);
        async_reset("rst_oor");

        // Simultaneous strobes: no write, err sticks
        cyc("rdwr5", 1, 1, 5, 8'hFF);
        check("rdwr5.err", 32'(err), 32'h1);
        cyc("rdwr5_end", 0, 0, 5, 8'h00);
        cyc("rd5", 1, 0, 5, 8'h00);
        check("rd5.literal", 32'(data_out), 32'h00);
        cyc("rd5_end", 0, 0, 5, 8'h00);
        check("err_sticky", 32'(err), 32'h1);

        // Crossed strobes while an access is in progress
        async_reset("rst_cross");
        cyc("x_rd", 1, 0, 4, 8'h00);
        cyc("x_rd_wr", 0, 1, 4, 8'h44);
        cyc("x_wr_next", 0, 1, 4, 8'h44);
        cyc("x_wr_rd", 1, 0, 4, 8'h00);
        cyc("x_idle", 0, 0, 4, 8'h00);

        // Reset during a write to 9 wipes it; held strobe restarts afterwards
        cyc("wr9", 0, 1, 9, 8'h99);
        rd = 1'b0;
        wr = 1'b1;
        async_reset("rst_wr9");
        check("rst_wr9.ack", 32'(wr_ack), 32'h0);
        cyc("wr9_restart", 0, 1, 9, 8'h66);
        cyc("wr9_end", 0, 0, 9, 8'h00);
        cyc("rd9", 1, 0, 9, 8'h00);
        check("rd9.literal", 32'(data_out), 32'h66);
        cyc("rd9_end", 0, 0, 9, 8'h00);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            int sel;
            bit r;
            bit w;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                async_reset("rand_rst");
            end else begin
                r = ($urandom_range(0, 9) < 4);
                w = ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 19) != 0 && r && w) w = 1'b0;
                cyc("rand", r, w, int'($urandom_range(0, 31)), 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: addr  in  5  word address, 32 locations.
REQ-004 SHALL have ports: data_in  in  8  write data, from accumulator when data_e is high.
REQ-005 SHALL have ports: rd  in  1  read strobe from controller.
REQ-006 SHALL have ports: wr  in  1  write strobe from controller.
REQ-007 SHALL have ports: data_out  out  8  registered read data.
REQ-008 SHALL have ports: data_valid  out  1  data_out holds the word for the current read.
REQ-009 SHALL have ports: wr_ack  out  1  one-cycle pulse, write committed.
REQ-010 SHALL have ports: err  out  1  sticky error flag.
REQ-011 SHALL have parameter: DEPTH, default 32, number of 8-bit words (addr width fixed at 5).

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE; IDLE is the reset state.
REQ-013 IDLE -> READ SHALL occur on the first clk edge with rd=1 and wr=0; mem[addr] is loaded into data_out on that edge.
REQ-014 In READ, data_out SHALL reload mem[addr] every cycle, so address changes are seen one cycle later, and data_valid SHALL be 1.
REQ-015 READ -> IDLE SHALL occur on the first edge with rd=0; data_valid SHALL drop on that edge; data_out SHALL hold its last value.
REQ-016 IDLE -> WRITE SHALL occur on an edge with wr=1 and rd=0; mem[addr] <= data_in on that same edge, and wr_ack=1 for exactly that following cycle.
REQ-017 WRITE SHALL write only once per wr assertion; while wr stays high in WRITE, memory SHALL NOT be rewritten.
REQ-018 WRITE -> IDLE SHALL occur when wr=0.
REQ-019 Read latency SHALL be 1 cycle from rd sampled high to data_valid=1 with correct data_out.
REQ-020 rd=1 and wr=1 on the same edge, in any state, SHALL perform no write, keep or enter READ, and set err.
REQ-021 wr rising while in READ, or rd rising while in WRITE, SHALL be ignored until IDLE is reached, and SHALL set err.
REQ-022 addr >= DEPTH SHALL return 8'h00 on read, SHALL discard writes, and SHALL set err; wr_ack SHALL still pulse.
REQ-023 err SHALL clear only on rst.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, data_out=8'h00, data_valid=0, wr_ack=0, err=0, with no clock required.
REQ-025 rst SHALL clear all memory words to 8'h00.
REQ-026 rst asserted mid-read or mid-write SHALL abort the access, and no write SHALL commit on that edge.
REQ-027 After rst deasserts, a strobe already high SHALL be treated as a new access on the next edge.

Configuration
REQ-028 Macro MEM_WRITE_PROTECT_EN SHALL control write protection.
REQ-029 When MEM_WRITE_PROTECT_EN is defined, addresses 0-7 (program region) SHALL be read-only: writes are discarded, wr_ack still pulses, and err is set.
REQ-030 When MEM_WRITE_PROTECT_EN is undefined, all addresses below DEPTH SHALL be writable, with no protection logic.

Verification
REQ-031 Reset, then rd=1 at addr=3 -> next cycle data_valid=1, data_out=8'h00, err=0.
REQ-032 wr=1, addr=20, data_in=8'hA5 for 3 cycles, then rd at addr=20 -> wr_ack high for 1 cycle only, data_out=8'hA5.
REQ-033 rd held while addr steps 20->21, with mem[21]=8'h3C -> data_out=8'h3C one cycle after the change, data_valid stays 1.
REQ-034 rd=1 and wr=1 together at addr=5, data_in=8'hFF -> mem[5] unchanged, err=1 until rst.
REQ-035 MEM_WRITE_PROTECT_EN defined: write 8'h77 to addr=2 -> wr_ack pulses, readback 8'h00, err=1; macro undefined: readback 8'h77, err=0.
REQ-036 rst asserted mid-cycle during a wr to addr=9 -> outputs reset asynchronously, mem[9]=8'h00, state IDLE.
